vga_draw_arbiter: RTL
=====================

Name: vga_draw_arbiter

Overview:
- Sequences and shares the single write port of the 160x120, 3-bit-colour image RAM (the image_ram_1r1w instance).
- Two requesters share the port:
  - a manual single-pixel writer (switches plus a key);
  - a rectangle-fill engine that rasters a colour over a clipped box.
- Sits between the board I/O top level and the image RAM write inputs, in the CLOCK_50 domain.
- The VGA read side is untouched.

Parameters:
- XW, 8, x coordinate width
- YW, 7, y coordinate width
- CW, 3, colour width
- X_MAX, 159, last visible column
- Y_MAX, 119, last visible row

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- resetn  in  1  synchronous reset, active low
- man_req  in  1  manual write request level (top level drives ~KEY[1]); acted on at the rising edge only
- man_x  in  XW  manual pixel x
- man_y  in  YW  manual pixel y
- man_color  in  CW  manual pixel colour
- fill_start  in  1  single-cycle pulse that starts a rectangle fill
- fill_x0, fill_x1  in  XW  rectangle corner x values, in any order
- fill_y0, fill_y1  in  YW  rectangle corner y values, in any order
- fill_color  in  CW  fill colour
- busy  out  1  high while in FILL
- done  out  1  one-cycle pulse after the last fill pixel is written
- we  out  1  RAM write enable
- xw  out  XW  RAM write x
- yw  out  YW  RAM write y
- din  out  CW  RAM write data

Behaviour:
- Reset and outputs:
  - Reset is synchronous and active low: resetn=0 sampled at a CLOCK_50 edge clears everything.
  - Values after reset: we=0, xw=0, yw=0, din=0, busy=0, done=0, state=IDLE, man_pend=0, man_req_q=0.
  - All outputs are registered.
- Manual capture:
  - man_req_q holds the previous man_req.
  - A rising edge (man_req & ~man_req_q) sets man_pend and latches man_x, man_y and man_color.
  - An edge that arrives while man_pend=1 is ignored; the first latched values are kept.
  - Holding the key produces exactly one write.
- Arbitration: fixed priority, evaluated every cycle.
  - man_pend=1 wins. In the next cycle the block drives we=1 with the latched values and clears man_pend.
  - Latched x>X_MAX or y>Y_MAX: the write is dropped (we=0), man_pend is still cleared.
  - If a fill is active, the fill cursor does not advance in that cycle (one-cycle stall). No fill pixel is lost or repeated.
- FSM:
  - IDLE:
    - fill_start=1 latches the fill parameters:
      - xmin=min(x0,x1), xmax=max(x0,x1), ymin=min(y0,y1), ymax=max(y0,y1);
      - xmax is clamped to X_MAX and ymax to Y_MAX;
      - the colour is latched.
    - If xmin>X_MAX or ymin>Y_MAX, the box is empty: go to DONE with no writes.
    - Otherwise set cursor=(xmin,ymin) and go to FILL.
    - fill_start together with a manual edge: both are accepted; the manual write goes first.
  - FILL:
    - busy=1.
    - Each cycle not taken by a manual write: we=1, xw/yw=cursor, din=fill colour.
    - Cursor advances x+1; at x==xmax it wraps to x=xmin and y+1.
    - After writing (xmax,ymax), go to DONE.
    - fill_start is ignored while in FILL.
  - DONE: one cycle; done=1, busy=0; return to IDLE. fill_start is ignored here.
- Latency:
  - fill_start at edge N gives busy=1 and the first pixel write at edge N+1.
  - A WxH box with no manual stalls: last write at N+W*H; done=1 at N+W*H+1.
  - Each manual write during a fill adds one cycle.
  - Manual edge sampled at edge N gives we=1 at edge N+1 (N+2 if the edge was sampled in the same cycle as the stall decision; the bench checks for exactly one write within 2 cycles).
- Reset mid-fill: the fill aborts, no done pulse is produced, we=0 from the next edge onward.
- Arithmetic: the cursor compares use unsigned XW/YW widths; there is no wrap past X_MAX/Y_MAX because of the clamp.

Decomposition:
- Package vga_draw_pkg holds:
  - XW, YW, CW, X_MAX, Y_MAX;
  - the state encoding: IDLE=2'd0, FILL=2'd1, DONE=2'd2.
- One sub-module, rect_raster_cursor, holds:
  - the min/max/clamp logic;
  - the cursor registers;
  - the advance enable input and the last-pixel flag output.
- The top-level block holds the edge detect, the pending flag, the arbitration mux and the FSM.

Test Plan:
- Reset → resetn=0 for 2 cycles mid-fill → we=0, busy=0, done=0, no further writes, no done pulse.
- Manual write → man_req held high for 10 cycles with (37,52,colour 5) → exactly one we=1 with xw=37, yw=52, din=5.
- Normal fill → fill_start with x0=12, x1=10, y0=5, y1=6, colour 3 → 6 writes in order (10,5)(11,5)(12,5)(10,6)(11,6)(12,6) on consecutive cycles; done exactly one cycle after the last write; busy high for 6 cycles.
- Clamped fill → fill_start with x0=158, x1=200, y0=119, y1=119 → writes (158,119),(159,119) only, then done.
- Empty box → x0=x1=170 → zero writes; done pulses at N+1.
- Manual during fill → fill 4x1 at (0,0), manual edge (80,60,colour 7) at the second fill cycle → write sequence (0,0),(80,60),(1,0),(2,0),(3,0); done one cycle later than the unstalled case.

Source files
------------

// File: rtl/vga_draw_pkg.sv
// Shared widths, screen limits and FSM encoding for the image RAM write-port arbiter.
package vga_draw_pkg;

    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    localparam logic [XW-1:0] X_MAX = 8'd159;
    localparam logic [YW-1:0] Y_MAX = 7'd119;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rect_raster_cursor.sv
// Normalises and clips a rectangle, then walks a raster cursor over it one pixel per advance.
module rect_raster_cursor
    import vga_draw_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic          advance,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          empty,
    output logic          last
);

    logic [XW-1:0] xmin_c, xmax_c;
    logic [YW-1:0] ymin_c, ymax_c;
    logic [XW-1:0] xmin_q, xmax_q;
    logic [YW-1:0] ymax_q;

    always_comb begin
        xmin_c = (x0 < x1) ? x0 : x1;
        xmax_c = (x0 < x1) ? x1 : x0;
        ymin_c = (y0 < y1) ? y0 : y1;
        ymax_c = (y0 < y1) ? y1 : y0;
        // Clamping the far corner keeps the cursor from ever stepping off screen.
        if (xmax_c > X_MAX) xmax_c = X_MAX;
        if (ymax_c > Y_MAX) ymax_c = Y_MAX;
    end

    assign empty = (xmin_c > X_MAX) || (ymin_c > Y_MAX);
    assign last  = (cur_x == xmax_q) && (cur_y == ymax_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            xmin_q <= '0;
            xmax_q <= '0;
            ymax_q <= '0;
            cur_x  <= '0;
            cur_y  <= '0;
        end else if (load) begin
            xmin_q <= xmin_c;
            xmax_q <= xmax_c;
            ymax_q <= ymax_c;
            cur_x  <= xmin_c;
            cur_y  <= ymin_c;
        end else if (advance && !last) begin
            if (cur_x == xmax_q) begin
                cur_x <= xmin_q;
                cur_y <= cur_y + 1'b1;
            end else begin
                cur_x <= cur_x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Shares the image RAM write port between a key-driven pixel writer and a rectangle-fill engine.
// Handshake: man_req is a level whose rising edge posts one write; fill_start is a one-cycle pulse honoured only in IDLE.
module vga_draw_arbiter
    import vga_draw_pkg::*;
(
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic          man_req,
    input  logic [XW-1:0] man_x,
    input  logic [YW-1:0] man_y,
    input  logic [CW-1:0] man_color,
    input  logic          fill_start,
    input  logic [XW-1:0] fill_x0,
    input  logic [XW-1:0] fill_x1,
    input  logic [YW-1:0] fill_y0,
    input  logic [YW-1:0] fill_y1,
    input  logic [CW-1:0] fill_color,
    output logic          busy,
    output logic          done,
    output logic          we,
    output logic [XW-1:0] xw,
    output logic [YW-1:0] yw,
    output logic [CW-1:0] din,
    output state_t        dbg_state
);

    state_t        state, state_next;
    logic          man_req_q, man_pend;
    logic [XW-1:0] man_x_q;
    logic [YW-1:0] man_y_q;
    logic [CW-1:0] man_c_q, fill_c_q;

    logic          load, advance, box_empty, box_last;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;

    logic          we_next, busy_next, done_next;
    logic [XW-1:0] xw_next;
    logic [YW-1:0] yw_next;
    logic [CW-1:0] din_next;

    rect_raster_cursor u_cursor (
        .clk     (CLOCK_50),
        .resetn  (resetn),
        .load    (load),
        .advance (advance),
        .x0      (fill_x0),
        .x1      (fill_x1),
        .y0      (fill_y0),
        .y1      (fill_y1),
        .cur_x   (cur_x),
        .cur_y   (cur_y),
        .empty   (box_empty),
        .last    (box_last)
    );

    // Edges arriving while a write is still pending are dropped so the first latched pixel wins.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            man_req_q <= 1'b0;
            man_pend  <= 1'b0;
            man_x_q   <= '0;
            man_y_q   <= '0;
            man_c_q   <= '0;
        end else begin
            man_req_q <= man_req;
            if (man_pend) begin
                man_pend <= 1'b0;
            end else if (man_req && !man_req_q) begin
                man_pend <= 1'b1;
                man_x_q  <= man_x;
                man_y_q  <= man_y;
                man_c_q  <= man_color;
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        we_next    = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        xw_next    = xw;
        yw_next    = yw;
        din_next   = din;

        // A pending manual write owns the port this cycle; off-screen pixels are silently dropped.
        if (man_pend) begin
            we_next  = (man_x_q <= X_MAX) && (man_y_q <= Y_MAX);
            xw_next  = man_x_q;
            yw_next  = man_y_q;
            din_next = man_c_q;
        end

        case (state)
            IDLE: begin
                if (fill_start) begin
                    load       = 1'b1;
                    state_next = box_empty ? DONE : FILL;
                end
            end
            FILL: begin
                busy_next = 1'b1;
                if (!man_pend) begin
                    we_next  = 1'b1;
                    xw_next  = cur_x;
                    yw_next  = cur_y;
                    din_next = fill_c_q;
                    advance  = 1'b1;
                    if (box_last) state_next = DONE;
                end
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state    <= IDLE;
            fill_c_q <= '0;
            we       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            xw       <= '0;
            yw       <= '0;
            din      <= '0;
        end else begin
            state <= state_next;
            if (load) fill_c_q <= fill_color;
            we    <= we_next;
            busy  <= busy_next;
            done  <= done_next;
            xw    <= xw_next;
            yw    <= yw_next;
            din   <= din_next;
        end
    end

    assign dbg_state = state;

endmodule
